mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Arbitrates one single-ported unified instruction/data memory between two requesters: the Fetch stage (IF, read-only) and the Memory stage (DM, load/store).
- Sequences each access through a fixed-latency memory, one access outstanding at a time.
- Routes read data back to the access's owner and produces stall signals for the hazard logic.
- Sits between the pipeline stages and the memory macro.

Parameters:
- MEM_LAT, 2: cycles from the issue cycle to the cycle `mem_rdata` is valid (legal range 1..15).
- STARVE_MAX, 4: number of consecutive DM grants made while `if_req` is pending before IF is forced to win.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous reset, active-high
- `if_req`  in  1  fetch read request
- `if_addr`  in  32  fetch address
- `if_gnt`  out  1  fetch request accepted this cycle
- `if_rvalid`  out  1  fetch data valid
- `if_rdata`  out  32  fetch data
- `dm_req`  in  1  data request
- `dm_we`  in  1  1 = store, 0 = load
- `dm_addr`  in  32  data address
- `dm_wdata`  in  32  store data
- `dm_be`  in  4  byte enables
- `dm_gnt`  out  1  data request accepted this cycle
- `dm_rvalid`  out  1  load data valid, or store completion
- `dm_rdata`  out  32  load data (0 for stores)
- `mem_req`  out  1  issue strobe to memory
- `mem_we`  out  1  write strobe
- `mem_addr`  out  32  memory address
- `mem_wdata`  out  32  memory write data
- `mem_be`  out  4  memory byte enables
- `mem_rdata`  in  32  memory read data, valid MEM_LAT cycles after issue
- `stall_if`  out  1  equals `if_req & ~if_gnt`
- `stall_dm`  out  1  equals `dm_req & ~dm_gnt`
- `perf_if_grants`  out  32  performance counter (see Optional Feature)
- `perf_dm_grants`  out  32  performance counter
- `perf_stall_cycles`  out  32  performance counter

Behaviour:
- State machine states are IDLE and WAIT. A 4-bit latency counter `lat_cnt` and a saturating 3-bit-or-wider starvation counter `starve_cnt` are kept.
- "Free" means state IDLE, or state WAIT with `lat_cnt == 0`.
- Arbitration happens only when free, and is combinational in that cycle:
  - Rule 1: if `dm_req` and not (`if_req` and `starve_cnt >= STARVE_MAX`), then DM wins.
  - Rule 2: otherwise, if `if_req`, then IF wins.
  - At most one of `if_gnt` and `dm_gnt` is 1.
- In the grant cycle:
  - `mem_req = 1`, and `mem_addr`/`mem_we`/`mem_wdata`/`mem_be` are driven from the winner.
  - For IF, `mem_we = 0`, `mem_be = 4'hF`, `mem_wdata = 0`.
  - On the next edge, the owner is latched, `lat_cnt <= MEM_LAT-1`, and the state goes to WAIT.
- When not granting, `mem_req`, `mem_we` and `mem_be` are 0, and `mem_addr`/`mem_wdata` are 0.
- In WAIT with `lat_cnt != 0`, `lat_cnt` decrements each cycle.
- In WAIT with `lat_cnt == 0` (response cycle):
  - The owner's rvalid is 1. For IF, `if_rdata = mem_rdata`. For a DM load, `dm_rdata = mem_rdata`. For a DM store, `dm_rdata = 0`.
  - Rdata outputs are 0 whenever their rvalid is 0.
  - In the same cycle a new grant may issue (back-to-back). Without a new grant, the next state is IDLE.
- Latency: an access granted in cycle T returns rvalid in cycle T+MEM_LAT. Peak throughput is one access per MEM_LAT cycles.
- Starvation counter:
  - Increments, saturating at STARVE_MAX, on each DM grant while `if_req` = 1.
  - Clears on any IF grant.
  - Unchanged otherwise.
- Requests are level-held by requesters until gnt. Request inputs are ignored when not free.
- Simultaneous requests with `starve_cnt < STARVE_MAX`: DM wins; `stall_if = 1`.
- Reset, including mid-transaction:
  - State goes to IDLE; `lat_cnt`, `starve_cnt` and owner clear to 0.
  - The in-flight access is abandoned and no rvalid is produced for it.
  - All outputs are 0 in the cycle after reset is sampled, and while reset is held.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- When defined:
  - `perf_if_grants` and `perf_dm_grants` count grants.
  - `perf_stall_cycles` counts cycles with `stall_if | stall_dm`.
  - All three are 32-bit, wrap at 2^32, and clear on reset.
- When undefined: the three ports remain present, tied to 0, and no counter flops are inferred.

Decomposition:
- Add to package Pkg:
  - `Arb_State_Case` enum: IDLE = 1'b0, WAIT = 1'b1.
  - `Arb_Owner_Case` enum: OWNER_IF = 1'b0, OWNER_DM = 1'b1.
  - `Mem_Req_Bundle` packed struct: we, addr[31:0], wdata[31:0], be[3:0].
- One sub-module, `arb_latency_timer`:
  - Loads MEM_LAT-1 on a start pulse and counts down.
  - Outputs `busy` and `done` (`done` = WAIT with count 0).
  - Synchronous active-high reset.

Test Plan:
- MEM_LAT=2; IF only, `if_addr = 0x100` at T, memory returns 0x00500093 → `if_gnt` at T; `mem_req` with `mem_addr = 0x100` at T; `if_rvalid` with `if_rdata = 0x00500093` at T+2; no other rvalid.
- Simultaneous requests: `if_req` and DM load at 0x2000 at T with `starve_cnt = 0` → `dm_gnt` at T, `stall_if = 1` at T, `dm_rvalid` at T+2; `if_gnt` at T+2 (back-to-back), `if_rvalid` at T+4.
- DM store: `dm_addr = 0x40`, `dm_wdata = 0xDEADBEEF`, `dm_be = 4'b0011` → memory sees `mem_we = 1`, `mem_be = 4'b0011`, data 0xDEADBEEF; `dm_rvalid = 1`, `dm_rdata = 0` at T+2.
- Starvation: STARVE_MAX=4, `dm_req` and `if_req` held continuously → grant order DM, DM, DM, DM, IF, DM...; `starve_cnt` returns to 0 after the IF grant.
- Reset mid-transaction: reset asserted at T+1 after a grant at T → no rvalid at T+2; state IDLE; a new `if_req` is granted in the first cycle after reset deasserts.
- ARB_PERF_CNT_EN defined, 3 IF grants, 2 DM grants, 5 stall cycles → `perf_if_grants = 3`, `perf_dm_grants = 2`, `perf_stall_cycles = 5`; macro undefined → all three ports read 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared types and helpers for the unified I/D memory port
//               arbiter (state/owner encodings, memory request bundle).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

    // Sequencer state: IDLE = no access in flight, WAIT = access in flight.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } Arb_State_Case;

    // Which requester owns the access currently in flight.
    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_DM = 1'b1
    } Arb_Owner_Case;

    // Everything the memory macro needs for one access besides the strobe.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } Mem_Req_Bundle;

    localparam logic [3:0] c_BE_FULL = 4'hF;

    // Fetches are always full-word reads with no write data.
    function automatic Mem_Req_Bundle f_if_bundle(input logic [31:0] addr);
        Mem_Req_Bundle b;
        b.we    = 1'b0;
        b.addr  = addr;
        b.wdata = 32'h0;
        b.be    = c_BE_FULL;
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_timer.sv
// ============================================================================
// Module      : arb_latency_timer
// Description : Tracks the single outstanding memory access. A start pulse
//               loads MEM_LAT-1 and the count runs down to the response
//               cycle, where done is raised. A start in the done cycle
//               reloads immediately (back-to-back issue).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_latency_timer
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    output logic o_busy,
    output logic o_done
);

    localparam logic [3:0] c_LOAD = 4'(MEM_LAT - 1);

    Arb_State_Case r_state;
    logic [3:0]    r_lat_cnt;

    // Sequencer: load on issue, count down while waiting, return to IDLE
    // after the response cycle unless a new access is issued in it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_lat_cnt <= 4'd0;
        end else if (i_start) begin
            r_state   <= WAIT;
            r_lat_cnt <= c_LOAD;
        end else if (r_state == WAIT) begin
            if (r_lat_cnt == 4'd0) begin
                r_state <= IDLE;
            end else begin
                r_lat_cnt <= r_lat_cnt - 4'd1;
            end
        end
    end

    assign o_busy = (r_state == WAIT);
    assign o_done = (r_state == WAIT) && (r_lat_cnt == 4'd0);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Arbitrates a single-ported unified memory between the fetch
//               stage (IF, read-only) and the memory stage (DM, load/store).
//               One fixed-latency access outstanding at a time; DM has
//               priority unless IF has been starved for STARVE_MAX grants.
//               Optional macro ARB_PERF_CNT_EN enables grant/stall counters;
//               without it the perf ports are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [3:0]  dm_be,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    output logic        stall_if,
    output logic        stall_dm,
    output logic [31:0] perf_if_grants,
    output logic [31:0] perf_dm_grants,
    output logic [31:0] perf_stall_cycles
);

    // Starvation counter must be able to hold STARVE_MAX; never below 3 bits.
    localparam int c_SW = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
    localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_MAX);

    logic            w_busy;
    logic            w_done;
    logic            w_free;
    logic            w_arb_en;
    logic            w_if_starved;
    logic            w_dm_win;
    logic            w_if_win;
    logic            w_resp;
    Mem_Req_Bundle   w_mem;

    Arb_Owner_Case   r_owner;
    logic            r_store;
    logic [c_SW-1:0] r_starve_cnt;

    arb_latency_timer #(
        .MEM_LAT (MEM_LAT)
    ) u_timer (
        .clk     (clk),
        .rst     (reset),
        .i_start (w_dm_win | w_if_win),
        .o_busy  (w_busy),
        .o_done  (w_done)
    );

    // Arbitration is only open when no access is in flight or the in-flight
    // one is in its response cycle; everything is suppressed during reset.
    assign w_free       = ~w_busy | w_done;
    assign w_arb_en     = w_free & ~reset;
    assign w_if_starved = if_req & (r_starve_cnt >= c_STARVE_MAX);
    assign w_dm_win     = w_arb_en & dm_req & ~w_if_starved;
    assign w_if_win     = w_arb_en & if_req & ~w_dm_win;

    assign if_gnt   = w_if_win;
    assign dm_gnt   = w_dm_win;
    assign stall_if = if_req & ~w_if_win & ~reset;
    assign stall_dm = dm_req & ~w_dm_win & ~reset;

    // Memory request mux: winner's fields in the grant cycle, zero otherwise.
    always_comb begin
        w_mem = '0;
        if (w_dm_win) begin
            w_mem.we    = dm_we;
            w_mem.addr  = dm_addr;
            w_mem.wdata = dm_wdata;
            w_mem.be    = dm_be;
        end else if (w_if_win) begin
            w_mem = f_if_bundle(if_addr);
        end
    end

    assign mem_req   = w_dm_win | w_if_win;
    assign mem_we    = w_mem.we;
    assign mem_addr  = w_mem.addr;
    assign mem_wdata = w_mem.wdata;
    assign mem_be    = w_mem.be;

    // Remember who owns the in-flight access and whether it is a store.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner <= OWNER_IF;
            r_store <= 1'b0;
        end else if (w_dm_win) begin
            r_owner <= OWNER_DM;
            r_store <= dm_we;
        end else if (w_if_win) begin
            r_owner <= OWNER_IF;
            r_store <= 1'b0;
        end
    end

    // Count DM grants that passed over a waiting fetch; any IF grant clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (w_if_win) begin
            r_starve_cnt <= '0;
        end else if (w_dm_win && if_req && (r_starve_cnt < c_STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    // Response routing: data only reaches the owner, and only in its cycle.
    assign w_resp    = w_done & ~reset;
    assign if_rvalid = w_resp & (r_owner == OWNER_IF);
    assign dm_rvalid = w_resp & (r_owner == OWNER_DM);
    assign if_rdata  = if_rvalid ? mem_rdata : 32'h0;
    assign dm_rdata  = (dm_rvalid && !r_store) ? mem_rdata : 32'h0;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] r_perf_if;
    logic [31:0] r_perf_dm;
    logic [31:0] r_perf_stall;

    // Free-running wrap-around grant and stall-cycle counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_if    <= 32'h0;
            r_perf_dm    <= 32'h0;
            r_perf_stall <= 32'h0;
        end else begin
            if (w_if_win)             r_perf_if    <= r_perf_if + 32'd1;
            if (w_dm_win)             r_perf_dm    <= r_perf_dm + 32'd1;
            if (stall_if || stall_dm) r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_if_grants    = reset ? 32'h0 : r_perf_if;
    assign perf_dm_grants    = reset ? 32'h0 : r_perf_dm;
    assign perf_stall_cycles = reset ? 32'h0 : r_perf_stall;
`else
    assign perf_if_grants    = 32'h0;
    assign perf_dm_grants    = 32'h0;
    assign perf_stall_cycles = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. A cycle-level
//               reference model checks every output each cycle; directed
//               scenarios pin the model with literal expectations, then a
//               randomized phase with occasional resets follows.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_gnt, dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        stall_if, stall_dm;
    logic [31:0] perf_if_grants, perf_dm_grants, perf_stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(
        .MEM_LAT    (MEM_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .if_req            (if_req),
        .if_addr           (if_addr),
        .if_gnt            (if_gnt),
        .if_rvalid         (if_rvalid),
        .if_rdata          (if_rdata),
        .dm_req            (dm_req),
        .dm_we             (dm_we),
        .dm_addr           (dm_addr),
        .dm_wdata          (dm_wdata),
        .dm_be             (dm_be),
        .dm_gnt            (dm_gnt),
        .dm_rvalid         (dm_rvalid),
        .dm_rdata          (dm_rdata),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_be            (mem_be),
        .mem_rdata         (mem_rdata),
        .stall_if          (stall_if),
        .stall_dm          (stall_dm),
        .perf_if_grants    (perf_if_grants),
        .perf_dm_grants    (perf_dm_grants),
        .perf_stall_cycles (perf_stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: one outstanding access described by its due cycle.
    // ------------------------------------------------------------------
    int  m_cyc    = 0;
    bit  m_pend   = 0;
    int  m_due    = 0;
    bit  m_own_dm = 0;
    bit  m_store  = 0;
    int  m_streak = 0;
    int  m_pif    = 0;
    int  m_pdm    = 0;
    int  m_pst    = 0;
    bit  m_if_gnt_last = 0;
    bit  m_dm_gnt_last = 0;

    bit          e_free, e_resp, e_dm, e_if, e_sif, e_sdm;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    logic        e_we;

    always @(negedge clk) begin
        e_resp = !reset && m_pend && (m_cyc == m_due);
        e_free = !m_pend || (m_cyc == m_due);
        e_dm   = !reset && e_free && dm_req && !(if_req && m_streak >= STARVE_MAX);
        e_if   = !reset && e_free && if_req && !e_dm;
        e_sif  = !reset && if_req && !e_if;
        e_sdm  = !reset && dm_req && !e_dm;
        e_we = 1'b0; e_addr = 32'h0; e_wdata = 32'h0; e_be = 4'h0;
        if (e_dm) begin
            e_we = dm_we; e_addr = dm_addr; e_wdata = dm_wdata; e_be = dm_be;
        end else if (e_if) begin
            e_addr = if_addr; e_be = 4'hF;
        end

        chk("if_gnt",    if_gnt,    e_if);
        chk("dm_gnt",    dm_gnt,    e_dm);
        chk("mem_req",   mem_req,   e_if | e_dm);
        chk("mem_we",    mem_we,    e_we);
        chk("mem_addr",  mem_addr,  e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("mem_be",    mem_be,    e_be);
        chk("stall_if",  stall_if,  e_sif);
        chk("stall_dm",  stall_dm,  e_sdm);
        chk("if_rvalid", if_rvalid, e_resp && !m_own_dm);
        chk("dm_rvalid", dm_rvalid, e_resp && m_own_dm);
        chk("if_rdata",  if_rdata,  (e_resp && !m_own_dm) ? mem_rdata : 32'h0);
        chk("dm_rdata",  dm_rdata,  (e_resp && m_own_dm && !m_store) ? mem_rdata : 32'h0);
`ifdef ARB_PERF_CNT_EN
        chk("perf_if",    perf_if_grants,    reset ? 32'h0 : 32'(m_pif));
        chk("perf_dm",    perf_dm_grants,    reset ? 32'h0 : 32'(m_pdm));
        chk("perf_stall", perf_stall_cycles, reset ? 32'h0 : 32'(m_pst));
`else
        chk("perf_if",    perf_if_grants,    32'h0);
        chk("perf_dm",    perf_dm_grants,    32'h0);
        chk("perf_stall", perf_stall_cycles, 32'h0);
`endif

        // Advance the model to what the next edge establishes.
        if (reset) begin
            m_pend = 0; m_streak = 0; m_pif = 0; m_pdm = 0; m_pst = 0;
        end else begin
            if (m_pend && m_cyc == m_due) m_pend = 0;
            if (e_dm || e_if) begin
                m_pend = 1; m_due = m_cyc + MEM_LAT;
                m_own_dm = e_dm; m_store = e_dm && dm_we;
            end
            if (e_if) m_streak = 0;
            else if (e_dm && if_req && m_streak < STARVE_MAX) m_streak++;
            if (e_if) m_pif++;
            if (e_dm) m_pdm++;
            if (e_sif || e_sdm) m_pst++;
        end
        m_if_gnt_last = e_if;
        m_dm_gnt_last = e_dm;
        m_cyc++;
    end

    task automatic cyc_start();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk); #1;
    endtask

    initial begin
        logic [5:0] seq;
        int         ng;
        bit [9:0]   p_if;
        bit [9:0]   p_dm;

        reset = 1'b1; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0;
        dm_addr = 0; dm_wdata = 0; dm_be = 0; mem_rdata = 32'h00500093;

        // Reset held with both requesters active: everything stays at 0.
        repeat (2) cyc_start();
        if_req = 1; dm_req = 1;
        mid();
        chk("rst_if_gnt", if_gnt, 0);
        chk("rst_dm_gnt", dm_gnt, 0);
        chk("rst_stall",  stall_if | stall_dm, 0);
        chk("rst_memreq", mem_req, 0);

        // IF-only fetch from 0x100.
        cyc_start(); reset = 0; dm_req = 0; if_addr = 32'h100;
        mid();
        chk("if_only_gnt",  if_gnt, 1);
        chk("if_only_addr", mem_addr, 32'h100);
        cyc_start(); if_req = 0;
        mid();
        chk("if_only_early", if_rvalid, 0);
        cyc_start(); mid();
        chk("if_only_rv",   if_rvalid, 1);
        chk("if_only_data", if_rdata, 32'h00500093);
        chk("if_only_dmrv", dm_rvalid, 0);

        // Simultaneous requests: DM first, IF back-to-back.
        cyc_start(); if_req = 1; if_addr = 32'h200; dm_req = 1; dm_we = 0; dm_addr = 32'h2000;
        mid();
        chk("sim_dm_gnt", dm_gnt, 1);
        chk("sim_if_gnt", if_gnt, 0);
        chk("sim_stall",  stall_if, 1);
        cyc_start(); dm_req = 0;
        cyc_start(); mid();
        chk("sim_dm_rv",   dm_rvalid, 1);
        chk("sim_dm_data", dm_rdata, 32'h00500093);
        chk("sim_if_b2b",  if_gnt, 1);
        chk("sim_b2b_adr", mem_addr, 32'h200);
        cyc_start(); if_req = 0;
        cyc_start(); mid();
        chk("sim_if_rv", if_rvalid, 1);

        // DM store.
        cyc_start(); dm_req = 1; dm_we = 1; dm_addr = 32'h40; dm_wdata = 32'hDEADBEEF; dm_be = 4'b0011;
        mid();
        chk("st_we",    mem_we, 1);
        chk("st_be",    mem_be, 4'b0011);
        chk("st_wdata", mem_wdata, 32'hDEADBEEF);
        cyc_start(); dm_req = 0; dm_we = 0;
        cyc_start(); mid();
        chk("st_rv",    dm_rvalid, 1);
        chk("st_rdata", dm_rdata, 32'h0);

        // Starvation: both held; expect DM,DM,DM,DM,IF,DM (1 = DM).
        cyc_start(); if_req = 1; dm_req = 1; dm_addr = 32'h3000;
        seq = '0; ng = 0;
        for (int k = 0; k < 40 && ng < 6; k++) begin
            mid();
            if (dm_gnt) begin seq[5-ng] = 1'b1; ng++; end
            else if (if_gnt) begin seq[5-ng] = 1'b0; ng++; end
            if (ng < 6) cyc_start();
        end
        chk("starve_count", ng, 6);
        chk("starve_order", {26'h0, seq}, 32'b111101);
        cyc_start(); if_req = 0; dm_req = 0;
        repeat (3) cyc_start();

        // Reset in the cycle after a grant abandons the access.
        if_req = 1; if_addr = 32'h300;
        mid();
        chk("mid_gnt", if_gnt, 1);
        cyc_start(); if_req = 0; reset = 1;
        mid();
        chk("mid_rst_rv",  if_rvalid, 0);
        chk("mid_rst_req", mem_req, 0);
        cyc_start(); reset = 0; if_req = 1; if_addr = 32'h304;
        mid();
        chk("mid_no_rv",  if_rvalid, 0);
        chk("mid_regrant", if_gnt, 1);
        chk("mid_addr",    mem_addr, 32'h304);
        cyc_start(); if_req = 0;
        repeat (3) cyc_start();

        // Perf: 3 IF grants, 2 DM grants, 5 stall cycles after a reset.
        reset = 1;
        p_if = 10'b0111011111;   // bit c = cycle c
        p_dm = 10'b0001000001;
        for (int c = 0; c < 10; c++) begin
            cyc_start();
            reset = 0; if_req = p_if[c]; dm_req = p_dm[c]; dm_we = 0;
        end
        mid();
`ifdef ARB_PERF_CNT_EN
        chk("perf_if_lit",    perf_if_grants, 3);
        chk("perf_dm_lit",    perf_dm_grants, 2);
        chk("perf_stall_lit", perf_stall_cycles, 5);
`else
        chk("perf_if_off",    perf_if_grants, 0);
        chk("perf_dm_off",    perf_dm_grants, 0);
        chk("perf_stall_off", perf_stall_cycles, 0);
`endif

        // Randomized traffic with level-held requests and rare resets.
        for (int i = 0; i < 2000; i++) begin
            cyc_start();
            reset = ($urandom_range(0, 99) == 0);
            if (!if_req || m_if_gnt_last) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = $urandom;
            end
            if (!dm_req || m_dm_gnt_last) begin
                dm_req   = ($urandom_range(0, 2) != 0);
                dm_we    = $urandom_range(0, 1);
                dm_addr  = $urandom;
                dm_wdata = $urandom;
                dm_be    = 4'($urandom);
            end
            mem_rdata = $urandom;
        end
        cyc_start(); reset = 0; if_req = 0; dm_req = 0;
        repeat (4) cyc_start();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
